camif_dvp_capture: RTL

Captures an 8-bit DVP camera bus (vsync/href/data) that has already been sampled into the ACLK domain. Packs byte pairs into 16-bit pixels and emits them as an AXI4-Stream video stream with SOF on tuser and EOL on tlast. Sits directly downstream of the camif AXI4-Lite register slave, which supplies enable/control and reads back status, and upstream of the ISP/VDMA stream path.

---
 rtl/camif_dvp_capture.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/camif_dvp_capture.sv
// rtl/camif_dvp_capture.sv - DVP byte capture to 16-bit AXI4-Stream video (CAMIF_FRAME_STATS_EN adds frame size stats)
module camif_dvp_capture #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIM_W      = 12
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             dvp_vsync,
  input  logic             dvp_href,
  input  logic [7:0]       dvp_data,
  input  logic             ctrl_enable,
  input  logic             ctrl_byte_swap,
  input  logic             ovf_clr,
  output logic [15:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic [15:0]      frame_cnt,
  output logic             overflow,
  output logic             busy,
  output logic [DIM_W-1:0] meas_width,
  output logic [DIM_W-1:0] meas_height
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, FRAME} state_t;

  state_t      state;
  logic        vsync_s1, href_s1, vsync_d, href_d;
  logic [7:0]  data_s1;
  logic        swap;
  logic        phase;
  logic [7:0]  hold;
  logic        pend_valid, pend_user, sof_pend;
  logic [15:0] pend_data;
  logic        push_req;
  logic [17:0] push_word;

  logic        vsync_fall, vsync_rise, href_fall;
  logic        in_frame, frame_start, frame_end;
  logic        byte_valid, pix_done;
  logic [15:0] pix_data;

  // Input stage S1 plus one delayed copy for edge detection
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      vsync_s1 <= 1'b0;
      href_s1  <= 1'b0;
      data_s1  <= 8'h00;
      vsync_d  <= 1'b0;
      href_d   <= 1'b0;
    end else begin
      vsync_s1 <= dvp_vsync;
      href_s1  <= dvp_href;
      data_s1  <= dvp_data;
      vsync_d  <= vsync_s1;
      href_d   <= href_s1;
    end
  end

  assign vsync_fall  = vsync_d & ~vsync_s1;
  assign vsync_rise  = ~vsync_d & vsync_s1;
  assign href_fall   = href_d & ~href_s1;
  assign in_frame    = (state == FRAME);
  assign frame_start = (state == ARM) && ctrl_enable && vsync_fall;
  assign frame_end   = in_frame && vsync_rise;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      busy      <= 1'b0;
      frame_cnt <= 16'h0000;
      swap      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_enable) state <= ARM;
        end
        ARM: begin
          if (!ctrl_enable) begin
            state <= IDLE;
          end else if (vsync_fall) begin
            state <= FRAME;
            busy  <= 1'b1;
            swap  <= ctrl_byte_swap;
          end
        end
        FRAME: begin
          if (vsync_rise) begin
            state     <= ctrl_enable ? ARM : IDLE;
            busy      <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_valid = in_frame & href_s1;
  assign pix_done   = byte_valid & phase;
  assign pix_data   = swap ? {data_s1, hold} : {hold, data_s1};

  // Phase clears whenever href is low, which discards a dangling odd byte
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      phase <= 1'b0;
      hold  <= 8'h00;
    end else if (!byte_valid) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
      if (!phase) hold <= data_s1;
    end
  end

  // One pixel is held back so that tlast can be attached when href falls
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pend_valid <= 1'b0;
      pend_user  <= 1'b0;
      pend_data  <= 16'h0000;
      sof_pend   <= 1'b0;
      push_req   <= 1'b0;
      push_word  <= 18'h00000;
    end else begin
      push_req <= 1'b0;
      if (frame_start) begin
        sof_pend   <= 1'b1;
        pend_valid <= 1'b0;
      end else if (in_frame) begin
        if (pix_done) begin
          if (pend_valid) begin
            push_req  <= 1'b1;
            push_word <= {pend_user, 1'b0, pend_data};
          end
          pend_valid <= 1'b1;
          pend_data  <= pix_data;
          pend_user  <= sof_pend;
          sof_pend   <= 1'b0;
        end else if (href_fall && pend_valid) begin
          push_req   <= 1'b1;
          push_word  <= {pend_user, 1'b1, pend_data};
          pend_valid <= 1'b0;
        end
        if (frame_end) pend_valid <= 1'b0;
      end else begin
        pend_valid <= 1'b0;
      end
    end
  end

  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en, ovf_set;
  logic [17:0]   head;

  assign full    = (count == DEPTH_C);
  assign pop     = m_axis_tvalid & m_axis_tready;
  assign wr_en   = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)   rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= ovf_set | (overflow & ~ovf_clr);
    end
  end

  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[15:0] : 16'h0000;
  assign m_axis_tlast  = m_axis_tvalid & head[16];
  assign m_axis_tuser  = m_axis_tvalid & head[17];

`ifdef CAMIF_FRAME_STATS_EN
  logic [DIM_W-1:0] pix_cnt, line_cnt, last_w;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pix_cnt     <= '0;
      line_cnt    <= '0;
      last_w      <= '0;
      meas_width  <= '0;
      meas_height <= '0;
    end else if (frame_start) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      last_w   <= '0;
    end else if (in_frame) begin
      if (pix_done && pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
      if (href_fall) begin
        pix_cnt <= '0;
        if (pix_cnt != '0) begin
          last_w <= pix_cnt;
          if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
        end
      end
      if (frame_end) begin
        meas_width  <= last_w;
        meas_height <= line_cnt;
      end
    end
  end
`else
  assign meas_width  = '0;
  assign meas_height = '0;
`endif

endmodule
